mem_checkpoint_monitor: RTL

- Synthesizable consumer of the 16-bit checkpoint word that management firmware drives on mprj_io[31:16] during the memory self-test.
- Decodes the word/short/byte phases of the test, enforces their order, and flags pass, fail, sequence error or watchdog timeout.
- Sits downstream of the caravel pad outputs, on the test-harness FPGA or the bring-up board logic.
- Replaces the hand-written behavioural checks with a reusable, clocked checker.

---
 rtl/mem_chkmon_pkg.sv | 70 +++++++
 rtl/mem_checkpoint_monitor_filter.sv | 43 ++++
 rtl/mem_checkpoint_monitor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_chkmon_pkg.sv
// Shared definitions for the memory self-test checkpoint monitor: code constants,
// FSM states, error codes and the checkpoint-word decoder.
package mem_chkmon_pkg;

    localparam logic [15:0] CHK_START_BASE = 16'hA000;
    localparam logic [15:0] CHK_END_BASE   = 16'hAB00;

    localparam logic [3:0] TAG_WORD  = 4'd4;
    localparam logic [3:0] TAG_SHORT = 4'd2;
    localparam logic [3:0] TAG_BYTE  = 4'd1;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_TEST_FAIL = 2'd1;
    localparam logic [1:0] ERR_SEQUENCE  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    localparam logic [1:0] LAST_PHASE = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RUNNING,
        ST_DONE_PASS,
        ST_DONE_FAIL,
        ST_TIMEOUT
    } state_t;

    typedef enum logic [1:0] {
        CODE_START,
        CODE_FAIL,
        CODE_PASS
    } code_kind_t;

    typedef struct packed {
        logic       known;
        code_kind_t kind;
        logic [1:0] phase;
    } code_t;

    function automatic logic [3:0] phase_tag(input logic [1:0] phase);
        case (phase)
            2'd0:    return TAG_WORD;
            2'd1:    return TAG_SHORT;
            default: return TAG_BYTE;
        endcase
    endfunction

    // Anything that is not START/FAIL/PASS with a valid phase tag decodes as unknown.
    function automatic code_t decode_code(input logic [15:0] word);
        code_t c;
        c = '{known: 1'b0, kind: CODE_START, phase: 2'd0};
        for (int p = 0; p < 3; p++) begin
            if (word[7:4] == phase_tag(2'(p))) begin
                c.phase = 2'(p);
                if (word[15:8] == CHK_START_BASE[15:8] && word[3:0] == 4'h0) begin
                    c.known = 1'b1;
                    c.kind  = CODE_START;
                end else if (word[15:8] == CHK_END_BASE[15:8] && word[3:0] == 4'h0) begin
                    c.known = 1'b1;
                    c.kind  = CODE_FAIL;
                end else if (word[15:8] == CHK_END_BASE[15:8] && word[3:0] == 4'h1) begin
                    c.known = 1'b1;
                    c.kind  = CODE_PASS;
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mem_checkpoint_monitor_filter.sv
// Stability filter for the pad checkpoint word: registers the input, counts
// consecutive identical samples and accepts a word once, when it first becomes stable.
module chkmon_stable_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] checkbits,
    output logic        accept,
    output logic [15:0] word
);

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    logic [15:0] sample_q;
    logic [15:0] last_q;
    logic [7:0]  count_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            sample_q <= '0;
            last_q   <= '0;
            count_q  <= '0;
        end else begin
            sample_q <= checkbits;
            if (checkbits != sample_q) begin
                count_q <= 8'd1;
            end else if (count_q != STABLE_LIMIT) begin
                count_q <= count_q + 8'd1;
            end
            if (accept) begin
                last_q <= sample_q;
            end
        end
    end

    // Remembering the last accepted word stops a glitch-and-return from re-firing.
    assign accept = (count_q == STABLE_LIMIT) && (sample_q != last_q);
    assign word   = sample_q;

endmodule

// File: rtl/mem_checkpoint_monitor.sv
// Checkpoint monitor for the memory self-test: filters the pad word, sequences the
// word/short/byte phases and reports pass/fail. Watchdog built when MEM_CHKMON_WATCHDOG_EN is defined.
module mem_checkpoint_monitor
    import mem_chkmon_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 300000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] checkbits,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [1:0]  phase,
    output logic [2:0]  phases_passed,
    output logic [1:0]  err_code,
    output logic        evt_strobe,
    output logic [15:0] evt_word
);

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  passed_q, passed_d;
    logic [1:0]  err_q, err_d;
    logic        accept;
    logic [15:0] filt_word;
    code_t       code;
    logic        code_hit;
    logic        active;
    logic        terminal;
    logic        wd_hit;

    chkmon_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clock    (clock),
        .reset    (reset),
        .checkbits(checkbits),
        .accept   (accept),
        .word     (filt_word)
    );

    assign code     = decode_code(filt_word);
    assign code_hit = accept && code.known;
    assign active   = (state_q == ST_WAIT_START) || (state_q == ST_RUNNING);
    assign terminal = (state_q == ST_DONE_PASS) || (state_q == ST_DONE_FAIL) ||
                      (state_q == ST_TIMEOUT);

`ifdef MEM_CHKMON_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;

    // Runs across phase changes; saturates so the limit stays visible after reaching it.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q <= '0;
        end else if (active && wd_q != WD_LIMIT) begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign wd_hit = active && (wd_q >= WD_LAST);
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= 2'd0;
            passed_q <= 3'd0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            passed_q <= passed_d;
            err_q    <= err_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        passed_d = passed_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT_START;
                    phase_d = 2'd0;
                end
            end
            ST_WAIT_START: begin
                if (code_hit) begin
                    if (code.kind == CODE_START && code.phase == phase_q) begin
                        state_d = ST_RUNNING;
                    end else begin
                        state_d = ST_DONE_FAIL;
                        err_d   = ERR_SEQUENCE;
                    end
                end else if (wd_hit) begin
                    state_d = ST_TIMEOUT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_RUNNING: begin
                if (code_hit) begin
                    if (code.phase != phase_q || code.kind == CODE_START) begin
                        state_d = ST_DONE_FAIL;
                        err_d   = ERR_SEQUENCE;
                    end else if (code.kind == CODE_FAIL) begin
                        state_d = ST_DONE_FAIL;
                        err_d   = ERR_TEST_FAIL;
                    end else begin
                        passed_d[phase_q] = 1'b1;
                        if (phase_q == LAST_PHASE) begin
                            state_d = ST_DONE_PASS;
                        end else begin
                            phase_d = phase_q + 2'd1;
                            state_d = ST_WAIT_START;
                        end
                    end
                end else if (wd_hit) begin
                    state_d = ST_TIMEOUT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        done          = terminal;
        pass          = (state_q == ST_DONE_PASS);
        fail          = (state_q == ST_DONE_FAIL);
        timeout       = (state_q == ST_TIMEOUT);
        phase         = phase_q;
        phases_passed = passed_q;
        err_code      = err_q;
    end

    // Events are reported until a verdict is reached; afterwards the pads are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            evt_strobe <= 1'b0;
            evt_word   <= '0;
        end else begin
            evt_strobe <= code_hit && !terminal;
            if (code_hit && !terminal) begin
                evt_word <= filt_word;
            end
        end
    end

endmodule
